// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for an up-to-8-digit seven-segment display.
// The divided scan clock is sampled as data, synchronized and edge-detected into a
// one-cycle tick; each tick advances one digit, with a blanking gap between digits.
// Display data is double-buffered (staging -> shadow) and swapped only at the frame wrap.
// Optional feature macro: SEG_LZ_SUPPRESS_EN (leading-zero suppression).
// Handshake: load is a one-cycle strobe with no back-pressure; load_ack pulses for one
// cycle on the clk edge where the shadow takes new data (the edge after the wrap tick).
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 4,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_clk,
  input  logic [31:0] digits,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_en,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_done,
  output logic [6:0]  seg,
  output logic        dp_out,
  output logic [7:0]  an
);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  localparam logic [2:0] LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [7:0] BLANK_INIT = 8'(BLANK_CYCLES);
  localparam logic [7:0] DIGIT_MASK = 8'((1 << NUM_DIGITS) - 1);
  localparam logic [6:0] SEG_POL    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0] AN_POL     = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic       DP_POL     = ACTIVE_LOW;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // sync_q[0..1] synchronize scan_clk, sync_q[2] is the previous synchronized value
  logic [2:0]  sync_q;
  logic        tick;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  idx, idx_n;

  logic [31:0] stg_digits, sh_digits, sh_digits_n;
  logic [7:0]  stg_dp, sh_dp, sh_dp_n;
  logic [7:0]  stg_en, sh_en, sh_en_n;
  logic        pending, pending_n;
  logic        wrap, ack_n;

  logic [3:0]  nib;
  logic        lz_hide;
  logic        lit;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  // Synchronize scan_clk and turn each rising edge into a registered one-clk tick
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b000;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], scan_clk};
      tick   <= sync_q[1] & ~sync_q[2];
    end
  end

  // Scan FSM next state: blank countdown, then show until the next tick
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    case (state)
      ST_BLANK: begin
        // Ticks during the blank are ignored; the last count cycle moves to SHOW
        if (cnt <= 8'd1) state_n = ST_SHOW;
        else             cnt_n   = cnt - 8'd1;
      end
      ST_SHOW: begin
        if (tick) begin
          idx_n   = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
          state_n = ST_BLANK;
          cnt_n   = BLANK_INIT;
        end
      end
      default: state_n = ST_BLANK;
    endcase
  end

  // Shadow swap at the frame wrap; a load on the wrap cycle bypasses staging
  always_comb begin
    wrap        = (state == ST_SHOW) && tick && (idx == LAST_IDX);
    sh_digits_n = sh_digits;
    sh_dp_n     = sh_dp;
    sh_en_n     = sh_en;
    pending_n   = pending | load;
    ack_n       = 1'b0;
    if (wrap) begin
      pending_n = 1'b0;
      if (load) begin
        sh_digits_n = digits;
        sh_dp_n     = dp;
        sh_en_n     = digit_en;
        ack_n       = 1'b1;
      end else if (pending) begin
        sh_digits_n = stg_digits;
        sh_dp_n     = stg_dp;
        sh_en_n     = stg_en;
        ack_n       = 1'b1;
      end
    end
  end

`ifdef SEG_LZ_SUPPRESS_EN
  logic [2:0] top_nz;

  // Highest nonzero shadow nibble; digits above it are hidden (digit 0 never is)
  always_comb begin
    top_nz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sh_digits_n[i*4 +: 4] != 4'h0) top_nz = 3'(i);
    end
    lz_hide = (idx_n > top_nz);
  end
`else
  // Every enabled digit is shown, leading zeros included
  always_comb begin
    lz_hide = 1'b0;
  end
`endif

  // Output values for the cycle after the edge, so the outputs are registered
  always_comb begin
    nib   = sh_digits_n[{idx_n, 2'b00} +: 4];
    lit   = (state_n == ST_SHOW) && sh_en_n[idx_n] && DIGIT_MASK[idx_n] && !lz_hide;
    an_n  = 8'h00;
    seg_n = 7'h00;
    dp_n  = 1'b0;
    if (lit) begin
      an_n  = 8'b1 << idx_n;
      seg_n = hex_to_seg(nib);
      dp_n  = sh_dp_n[idx_n];
    end
  end

  // FSM, staging and shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BLANK;
      cnt        <= BLANK_INIT;
      idx        <= 3'd0;
      stg_digits <= 32'h0;
      stg_dp     <= 8'h00;
      stg_en     <= 8'h00;
      sh_digits  <= 32'h0;
      sh_dp      <= 8'h00;
      sh_en      <= 8'h00;
      pending    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh_digits <= sh_digits_n;
      sh_dp     <= sh_dp_n;
      sh_en     <= sh_en_n;
      pending   <= pending_n;
      if (load) begin
        stg_digits <= digits;
        stg_dp     <= dp;
        stg_en     <= digit_en;
      end
    end
  end

  // Registered, polarity-adjusted display outputs and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= AN_POL;
      seg        <= SEG_POL;
      dp_out     <= DP_POL;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      an         <= an_n ^ AN_POL;
      seg        <= seg_n ^ SEG_POL;
      dp_out     <= dp_n ^ DP_POL;
      load_ack   <= ack_n;
      frame_done <= wrap;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for an 8-digit seven-segment display that consumes the divided scan clock produced by the frequency divider. It treats that divided clock as data in the system clock domain and advances one digit per scan-clock rising edge. It decodes hex nibbles to segment patterns and inserts a ghosting blank between digits. Display data is double-buffered so a new value only appears at a frame boundary, with no tearing.

## Interface
Parameters:
- NUM_DIGITS, 8, digits scanned; legal 1..8. Unused anode bits are held off.
- BLANK_CYCLES, 4, number of clk cycles with all anodes off after each digit switch; legal 1..255.
- ACTIVE_LOW, 0, when 1 invert `seg`, `dp_out` and `an` at the output.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- scan_clk  in  1  divided clock from the frequency divider; asynchronous to logic use, so it is synchronized.
- digits  in  32  nibble i = digit i (digit 0 = bits 3:0, rightmost).
- dp  in  8  decimal point per digit.
- digit_en  in  8  per-digit enable mask.
- load  in  1  one-cycle strobe; captures digits/dp/digit_en into staging.
- load_ack  out  1  one-cycle pulse when staging is copied to the display shadow.
- frame_done  out  1  one-cycle pulse on the wrap from digit NUM_DIGITS-1 to digit 0.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp_out  out  1  decimal point of the active digit.
- an  out  8  one-hot digit select.

## Operation
- scan_clk passes through a 2-flop synchronizer, then a rising-edge detector, producing `tick`, which is 1 clk wide.
- FSM states:
  - BLANK: `an` is all off; a counter loads BLANK_CYCLES and decrements; at 0 go to SHOW. A tick arriving in BLANK is dropped.
  - SHOW: `an` = onehot(idx) AND shadow_en[idx]; `seg`/`dp_out` come from the shadow. On tick: idx = (idx == NUM_DIGITS-1) ? 0 : idx+1; go to BLANK.
- Decode (active-high, hex 0–F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Staging and shadow:
  - On `load`, inputs go to staging and `pending` is set. A second load before the boundary overwrites staging.
  - On a wrap tick with `pending` set: shadow <= staging, `pending` is cleared, `load_ack` pulses.
  - If `load` and a wrap tick coincide, the shadow takes the live inputs directly and `load_ack` pulses that cycle.
- When an anode is disabled or blanked, `seg` and `dp_out` are also driven off.

## Timing
- All outputs are registered.
- Reset values:
  - state = BLANK, counter = BLANK_CYCLES, idx = 0.
  - staging, shadow and pending are cleared, so shadow_en = 0 and the display is dark.
  - `an`, `seg`, `dp_out` are off (polarity-adjusted); `load_ack` = 0; `frame_done` = 0.
- After reset the FSM enters SHOW on digit 0 after BLANK_CYCLES clks without needing a tick.
- Tick latency: `tick` asserts on the 3rd clk edge after scan_clk rises.
- `an` goes off on the clk edge after `tick`. The next digit's `an` asserts BLANK_CYCLES+1 edges after `tick`.
- Wrap tick: `frame_done` and `load_ack` assert on the clk edge after `tick`. The new shadow data is visible from the first SHOW of digit 0.
- Reset asserted mid-frame: all state returns to reset values on the next clk edge; a pending load is discarded.
- If scan_clk is held static, the display holds the current digit indefinitely.

## Configuration
- `SEG_LZ_SUPPRESS_EN` defined:
  - Digits above the highest nonzero shadow nibble have their anode forced off. Digit 0 is always shown if enabled.
  - A dp bit set on a suppressed digit does not un-suppress it.
- `SEG_LZ_SUPPRESS_EN` undefined: every enabled digit is shown, including leading zeros.

## Test plan
All tests use NUM_DIGITS=8, BLANK_CYCLES=2, ACTIVE_LOW=0.
- Reset, no load, scan_clk toggling every 20 clks -> `an` = 00 and `seg` = 00 throughout; FSM enters SHOW 2 clks after reset release.
- load digits=0x76543210, dp=0x01, digit_en=FF; run one full frame -> `load_ack` once at the first wrap. After that, digit i shows the decode of i (digit 0: seg=3F, dp_out=1; digit 7: seg=07). `an` walks 01,02,…,80 with 2 off-cycles between digits, and `frame_done` pulses once per 8 ticks.
- Two loads (0x11111111, then 0x22222222) inside one frame -> a single `load_ack`; the next frame shows seg=5B on all digits, and 0x11111111 is never displayed.
- `load` asserted on the same cycle as the wrap tick with digits=0x0000000F -> `load_ack` that cycle; digit 0 shows 71 immediately after the blank.
- scan_clk pulse arriving during BLANK -> ignored; idx advances only once.
- Reset pulsed while showing digit 5 with pending set -> next edge: `an` = 00, idx = 0; after BLANK the display stays dark and no `load_ack` occurs.
- With `SEG_LZ_SUPPRESS_EN` and digits=0x00000305 -> only `an` 01, 02, 04 are ever active.
